// File: rtl/dingshi_pkg.sv
// Shared types and helpers for the dingshi multi-channel countdown timer.
// Channel state encoding, parameter ranges and the load_sel width rule live here.
package dingshi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } chan_state_t;

    localparam int CH_MIN           = 1;
    localparam int CH_MAX           = 16;
    localparam int W_MIN            = 1;
    localparam int DEFAULT_CH       = 4;
    localparam int DEFAULT_W        = 8;
    localparam int DEFAULT_LOAD_VAL = 5;

    // A single channel still needs a one-bit select so the port never collapses.
    function automatic int sel_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/dingshi_chan.sv
// One countdown channel: FSM, down-counter, reload register, sticky done,
// registered expiry tick and activity LED.
module dingshi_chan
    import dingshi_pkg::*;
#(
    parameter int          W            = DEFAULT_W,
    parameter int unsigned DEFAULT_LOAD = DEFAULT_LOAD_VAL
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         open,
    input  logic         pause,
    input  logic         reload_mode,
    input  logic         load_we,
    input  logic [W-1:0] load_val,
    input  logic         done_clr,
    output logic [W-1:0] cnt,
    output logic         done,
    output logic         tick,
    output logic         led
);

    chan_state_t  state;
    logic [W-1:0] reload;
    logic         start_hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            reload     <= W'(DEFAULT_LOAD);
            cnt        <= W'(DEFAULT_LOAD);
            done       <= 1'b0;
            tick       <= 1'b0;
            led        <= 1'b0;
            start_hold <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (load_we) begin
                reload <= load_val;
            end
            if (done_clr) begin
                done <= 1'b0;
            end

            if (!open) begin
                state      <= ST_IDLE;
                cnt        <= load_we ? load_val : reload;
                led        <= 1'b0;
                start_hold <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state      <= ST_RUN;
                        led        <= 1'b1;
                        start_hold <= 1'b1;
                        if (load_we) begin
                            cnt <= load_val;
                        end
                    end
                    ST_RUN: begin
                        // The first unpaused cycle after leaving IDLE shows the full
                        // reload value once more before counting starts.
                        if (!pause) begin
                            if (start_hold) begin
                                start_hold <= 1'b0;
                            end else if (cnt != '0) begin
                                cnt <= cnt - W'(1);
                            end else begin
                                tick <= 1'b1;
                                done <= 1'b1;
                                if (reload_mode) begin
                                    cnt <= reload;
                                end else begin
                                    state <= ST_EXPIRED;
                                    led   <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_EXPIRED: begin
                        led <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= reload;
                        led   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/dingshi_multi.sv
// Multi-channel countdown timer: CH independent channels sharing one reload
// write bus, with the per-channel counts packed onto a single output vector.
module dingshi_multi
    import dingshi_pkg::*;
#(
    parameter int          CH           = DEFAULT_CH,
    parameter int          W            = DEFAULT_W,
    parameter int unsigned DEFAULT_LOAD = DEFAULT_LOAD_VAL
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CH-1:0]          open,
    input  logic [CH-1:0]          pause,
    input  logic [CH-1:0]          reload_mode,
    input  logic                   load_we,
    input  logic [sel_w(CH)-1:0]   load_sel,
    input  logic [W-1:0]           load_val,
    input  logic [CH-1:0]          done_clr,
    output logic [CH*W-1:0]        cnt,
    output logic [CH-1:0]          done,
    output logic [CH-1:0]          tick,
    output logic [CH-1:0]          led
);

    localparam int SEL_W = sel_w(CH);

    if (CH < CH_MIN || CH > CH_MAX || W < W_MIN) begin : g_bad_param
        $error("dingshi_multi: CH must be 1..16 and W at least 1");
    end

    // A select value at or above CH matches no channel, so such writes are dropped.
    for (genvar k = 0; k < CH; k++) begin : g_chan
        logic chan_we;

        assign chan_we = load_we && (load_sel == SEL_W'(k));

        dingshi_chan #(
            .W            (W),
            .DEFAULT_LOAD (DEFAULT_LOAD)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .open        (open[k]),
            .pause       (pause[k]),
            .reload_mode (reload_mode[k]),
            .load_we     (chan_we),
            .load_val    (load_val),
            .done_clr    (done_clr[k]),
            .cnt         (cnt[k*W +: W]),
            .done        (done[k]),
            .tick        (tick[k]),
            .led         (led[k])
        );
    end

endmodule

// File: tb/tb_dingshi_multi.sv
// Bench for dingshi_multi: directed scenarios then random traffic, every cycle
// compared against a time-to-next-expiry model of each channel.
module tb_dingshi_multi;

    localparam int CH = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   open, pause, reload_mode, done_clr;
    logic            load_we;
    logic [SW-1:0]   load_sel;
    logic [W-1:0]    load_val;
    logic [CH*W-1:0] cnt;
    logic [CH-1:0]   done, tick, led;

    logic [2:0]  open3, pause3, mode3, clr3;
    logic        we3;
    logic [1:0]  sel3;
    logic [7:0]  val3;
    logic [23:0] cnt3;
    logic [2:0]  done3, tick3, led3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dingshi_multi #(.CH(CH), .W(W), .DEFAULT_LOAD(5)) dut (
        .clk(clk), .rst(rst), .open(open), .pause(pause), .reload_mode(reload_mode),
        .load_we(load_we), .load_sel(load_sel), .load_val(load_val), .done_clr(done_clr),
        .cnt(cnt), .done(done), .tick(tick), .led(led)
    );

    dingshi_multi #(.CH(3), .W(8), .DEFAULT_LOAD(5)) dut3 (
        .clk(clk), .rst(rst), .open(open3), .pause(pause3), .reload_mode(mode3),
        .load_we(we3), .load_sel(sel3), .load_val(val3), .done_clr(clr3),
        .cnt(cnt3), .done(done3), .tick(tick3), .led(led3)
    );

    // Model: a running channel knows how many unpaused edges remain until it
    // expires (rem) and the reload value of the current period (seg).
    bit m_run[CH], m_exp[CH], m_done[CH], m_tick[CH];
    int m_rem[CH], m_seg[CH], m_rel[CH];

    function automatic int m_cnt(input int k);
        if (m_exp[k]) return 0;
        if (m_run[k]) return (m_seg[k] < m_rem[k] - 1) ? m_seg[k] : m_rem[k] - 1;
        return m_rel[k];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < CH; k++) begin
            m_run[k] = 0; m_exp[k] = 0; m_done[k] = 0; m_tick[k] = 0;
            m_rem[k] = 0; m_seg[k] = 0; m_rel[k] = 5;
        end
    endtask

    task automatic model_edge();
        int nrel[CH];
        for (int k = 0; k < CH; k++) begin
            nrel[k] = m_rel[k];
            if (load_we && int'(load_sel) == k) nrel[k] = int'(load_val);
        end
        for (int k = 0; k < CH; k++) begin
            m_tick[k] = 0;
            if (done_clr[k]) m_done[k] = 0;
            if (!open[k]) begin
                m_run[k] = 0; m_exp[k] = 0;
            end else if (!m_run[k] && !m_exp[k]) begin
                m_run[k] = 1; m_seg[k] = nrel[k]; m_rem[k] = nrel[k] + 2;
            end else if (m_run[k] && !pause[k]) begin
                if (m_rem[k] == 1) begin
                    m_tick[k] = 1; m_done[k] = 1;
                    if (reload_mode[k]) begin
                        m_seg[k] = m_rel[k]; m_rem[k] = m_rel[k] + 1;
                    end else begin
                        m_run[k] = 0; m_exp[k] = 1;
                    end
                end else begin
                    m_rem[k] = m_rem[k] - 1;
                end
            end
        end
        for (int k = 0; k < CH; k++) m_rel[k] = nrel[k];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < CH; k++) begin
            chk($sformatf("%s cnt%0d", tag, k), 32'(cnt[k*W +: W]), m_cnt(k));
            chk($sformatf("%s done%0d", tag, k), 32'(done[k]), 32'(m_done[k]));
            chk($sformatf("%s tick%0d", tag, k), 32'(tick[k]), 32'(m_tick[k]));
            chk($sformatf("%s led%0d", tag, k), 32'(led[k]), 32'(m_run[k]));
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        int ticks, tick_edge;

        rst = 1'b0;
        open = '0; pause = '0; reload_mode = '0; done_clr = '0;
        load_we = 1'b0; load_sel = '0; load_val = '0;
        open3 = '0; pause3 = '0; mode3 = '0; clr3 = '0; we3 = 1'b0; sel3 = '0; val3 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < CH; k++) begin
            chk($sformatf("reset cnt%0d", k), 32'(cnt[k*W +: W]), 32'd5);
        end
        chk("reset done", 32'(done), 32'd0);
        chk("reset tick", 32'(tick), 32'd0);
        chk("reset led", 32'(led), 32'd0);
        rst = 1'b1;

        // One-shot countdown on ch0 from the default reload of 5.
        open[0] = 1'b1;
        for (int e = 0; e <= 8; e++) begin
            step("oneshot");
            if (e == 6) chk("oneshot cnt0 zero", 32'(cnt[7:0]), 32'd0);
            if (e == 7) chk("oneshot tick0 edge7", 32'(tick[0]), 32'd1);
            if (e == 7) chk("oneshot led0 falls", 32'(led[0]), 32'd0);
            if (e == 8) chk("oneshot tick0 single", 32'(tick[0]), 32'd0);
        end
        open[0] = 1'b0;
        step("oneshot close");

        // Auto-reload on ch1 with reload 3 written while idle.
        load_we = 1'b1; load_sel = 2'd1; load_val = 8'd3;
        step("load idle");
        chk("load idle cnt1", 32'(cnt[15:8]), 32'd3);
        load_we = 1'b0;
        reload_mode[1] = 1'b1; open[1] = 1'b1;
        ticks = 0;
        for (int e = 0; e <= 13; e++) begin
            step("auto");
            if (tick[1]) ticks++;
        end
        chk("auto tick count", 32'(ticks), 32'd3);
        done_clr[1] = 1'b1;
        step("auto clr");
        done_clr[1] = 1'b0;
        chk("auto done1 cleared", 32'(done[1]), 32'd0);
        step("auto");
        step("auto");
        step("auto");
        chk("auto done1 back", 32'(done[1]), 32'd1);

        // Pause ch2 for three cycles while its count is 4.
        open[2] = 1'b1;
        tick_edge = -1;
        for (int e = 0; e <= 11; e++) begin
            pause[2] = (e >= 3 && e <= 5);
            step("pause");
            if (e == 5) chk("pause cnt2 held", 32'(cnt[23:16]), 32'd4);
            if (e == 5) chk("pause led2 held", 32'(led[2]), 32'd1);
            if (tick[2] && tick_edge < 0) tick_edge = e;
        end
        pause[2] = 1'b0;
        chk("pause tick2 edge", 32'(tick_edge), 32'd10);

        // Drop open on ch3 once it is down to 2.
        open[3] = 1'b1;
        for (int e = 0; e <= 4; e++) step("drop");
        chk("drop cnt3 before", 32'(cnt[31:24]), 32'd2);
        open[3] = 1'b0;
        step("drop");
        chk("drop cnt3 reload", 32'(cnt[31:24]), 32'd5);
        chk("drop tick3", 32'(tick[3]), 32'd0);

        // Reload write to ch0 mid-run leaves the running count alone.
        open[0] = 1'b1;
        for (int e = 0; e <= 3; e++) step("midload");
        load_we = 1'b1; load_sel = 2'd0; load_val = 8'd9;
        step("midload");
        load_we = 1'b0;
        chk("midload cnt0 untouched", 32'(cnt[7:0]), 32'd2);
        for (int e = 5; e <= 8; e++) step("midload");
        open[0] = 1'b0;
        step("midload close");
        chk("midload cnt0 reload9", 32'(cnt[7:0]), 32'd9);
        open[0] = 1'b1;
        step("midload reopen");
        chk("midload reopen cnt0", 32'(cnt[7:0]), 32'd9);

        // Random traffic with short reload values.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < CH; k++) begin
                open[k]        = ($urandom_range(0, 9) != 0);
                pause[k]       = ($urandom_range(0, 3) == 0);
                reload_mode[k] = ($urandom_range(0, 1) == 1);
                done_clr[k]    = ($urandom_range(0, 7) == 0);
            end
            load_we  = ($urandom_range(0, 5) == 0);
            load_sel = SW'($urandom_range(0, CH - 1));
            load_val = W'($urandom_range(0, 6));
            step("random");
        end

        // Asynchronous reset in the middle of a cycle with everything running.
        open = '1; pause = '0; done_clr = '0; load_we = 1'b0; reload_mode = 4'b1010;
        for (int e = 0; e < 4; e++) step("prerst");
        #2;
        rst = 1'b0;
        #1;
        for (int k = 0; k < CH; k++) begin
            chk($sformatf("async cnt%0d", k), 32'(cnt[k*W +: W]), 32'd5);
        end
        chk("async done", 32'(done), 32'd0);
        chk("async tick", 32'(tick), 32'd0);
        chk("async led", 32'(led), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_all("in reset");
        rst = 1'b1;
        open = '0;
        step("after reset");

        // Out-of-range select on a three-channel instance.
        we3 = 1'b1; sel3 = 2'd3; val3 = 8'd7;
        @(posedge clk);
        #1;
        chk("sel3 oob ch0", 32'(cnt3[7:0]), 32'd5);
        chk("sel3 oob ch1", 32'(cnt3[15:8]), 32'd5);
        chk("sel3 oob ch2", 32'(cnt3[23:16]), 32'd5);
        sel3 = 2'd2;
        @(posedge clk);
        #1;
        we3 = 1'b0;
        chk("sel3 valid ch2", 32'(cnt3[23:16]), 32'd7);
        chk("sel3 valid ch0", 32'(cnt3[7:0]), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dingshi_multi.md
Name: dingshi_multi

Overview:
- Parametrised multi-channel countdown timer; successor to the single fixed-5 countdown block.
- Per channel: programmable reload value, enable (open), pause, one-shot or auto-reload mode, sticky done flag with clear, single-cycle expiry tick, and activity LED.
- Sits between the panel/control logic, which drives open, load and pause, and the LED/alarm outputs.

Parameters:
- CH, 4, number of independent timer channels (1..16).
- W, 8, counter and reload width in bits.
- DEFAULT_LOAD, 5, reload value after reset (must fit in W bits).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous active-low reset.
- open  in  CH  per-channel run enable; level-sensitive.
- pause  in  CH  per-channel freeze; counter holds while high.
- reload_mode  in  CH  1 = auto-reload on expiry, 0 = one-shot.
- load_we  in  1  write strobe for the reload register.
- load_sel  in  max(1,$clog2(CH))  channel index for load_we.
- load_val  in  W  reload value written by load_we.
- done_clr  in  CH  per-channel clear of the sticky done flag.
- cnt  out  CH*W  current count; channel k occupies bits [k*W +: W].
- done  out  CH  sticky expiry flag.
- tick  out  CH  one-cycle pulse on each expiry.
- led  out  CH  high while the channel is RUN or PAUSED.

Behaviour:
- Reset (rst low, async, any time including mid-count):
  - reload[k]=DEFAULT_LOAD, cnt[k]=DEFAULT_LOAD.
  - done=0, tick=0, led=0, all channels in IDLE.
- Per-channel FSM (states IDLE, RUN, EXPIRED; "paused" is RUN with pause high):
- IDLE:
  - cnt holds reload and led=0.
  - If open=1 at an edge: go to RUN, led<=1, cnt unchanged (=reload).
- RUN, open=1:
  - pause=1: cnt, state and led hold; no expiry check, even at cnt==0.
  - pause=0, cnt>0: cnt<=cnt-1.
  - pause=0, cnt==0: tick<=1 and done<=1.
    - If reload_mode=1: cnt<=reload and stay in RUN.
    - Otherwise: go to EXPIRED, led<=0.
- EXPIRED: cnt holds 0, led=0, no further ticks. Leaves only when open drops.
- open=0 in any state: next edge goes to IDLE, cnt<=reload, led<=0, tick<=0. done is NOT cleared.
- Latency: with reload L, the first edge sampling open=1 is edge 0. cnt reaches 0 after edge L+1. tick and done are high after edge L+2, i.e. L+2 edges. Auto-reload period is L+1 cycles.
- L=0: tick on the second edge after open; in auto-reload mode tick stays high every cycle.
- tick is registered and high for exactly one cycle per expiry (except the L=0 auto-reload case above).
- load_we:
  - Writes reload[load_sel]<=load_val.
  - If that channel is IDLE, cnt also becomes load_val on the same edge.
  - If the channel is RUN or EXPIRED, the new value applies at the next reload or re-open; the current count is untouched.
  - load_sel>=CH: write ignored.
- done_clr: clears done on the next edge. If an expiry sets done on the same edge, the set wins.
- Arithmetic: unsigned W-bit. A decrement never occurs at 0, so there is no wrap-around.
- Channels are fully independent and share only the load bus.

Decomposition:
- Package dingshi_pkg holds:
  - state enum (IDLE, RUN, EXPIRED) as a 2-bit type;
  - localparam default ranges and the load_sel width function.
- Sub-module dingshi_chan contains one channel's FSM, counter, reload register and flags. dingshi_multi instantiates it CH times in a generate loop, decodes load_we/load_sel to a per-channel write enable, and packs cnt.

Test Plan:
- Reset default, ch0 open held high, no pause, one-shot → cnt 5,4,3,2,1,0. tick0 is a single pulse after edge 7 (counting from 0). done0=1, led0 falls on the same edge, cnt stays 0.
- ch1 reload_mode=1, load_val=3 written while IDLE, open high → tick1 pulses every 4 cycles; done1 stays 1. Assert done_clr1 between ticks → done1 drops, then returns on the next tick.
- ch2 running at cnt=4, pause high for 3 cycles → cnt holds 4 and led2 stays 1. After release, tick fires exactly 3 cycles later than without pause.
- ch3 running at cnt=2, open dropped → next edge IDLE, cnt3=reload, led3=0, no tick.
- Write load_val=9 to ch0 mid-run → current countdown is unaffected; after a re-open the count starts at 9.
- rst pulsed low mid-count on all channels → outputs return immediately to reset values with no clock edge. Also check load_sel=CH (when CH is not a power of two): no reload register changes.
